uart_word_tx_sched: RTL



---
 rtl/uart_word_tx_sched_pkg.sv | 18 +
 rtl/uart_word_tx_sched_word_fifo.sv | 56 +++++
 rtl/uart_word_tx_sched.sv | 99 +++++++++
 3 files changed

// File: rtl/uart_word_tx_sched_pkg.sv
// Shared definitions for the word-to-byte UART transmit scheduler:
// FSM state encodings and default parameter values.
package uart_word_tx_sched_pkg;

  localparam int NBITS_D_DEF   = 16;
  localparam int DBIT_DEF      = 8;
  localparam int FIFO_AW_DEF   = 2;
  localparam int NBITS_CNT_DEF = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND_LO = 3'd1,
    WAIT_LO = 3'd2,
    SEND_HI = 3'd3,
    WAIT_HI = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_word_tx_sched_word_fifo.sv
// Small synchronous FIFO holding result words; the head word is read
// combinationally so the scheduler can latch it in the same cycle it pops.
module word_fifo
  import uart_word_tx_sched_pkg::*;
#(
  parameter int NBITS_D = NBITS_D_DEF,
  parameter int FIFO_AW = FIFO_AW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [NBITS_D-1:0] din,
  output logic [NBITS_D-1:0] dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_COUNT = (FIFO_AW + 1)'(DEPTH);

  logic [NBITS_D-1:0] mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               push_ok;
  logic               pop_ok;

  // Count, not the pointers, decides full/empty since the pointers wrap.
  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_word_tx_sched.sv
// Buffers result words and serialises each one onto the uart_tx byte
// interface, low byte first, owning the tx start/done handshake.
module uart_word_tx_sched
  import uart_word_tx_sched_pkg::*;
#(
  parameter int NBITS_D   = NBITS_D_DEF,
  parameter int DBIT      = DBIT_DEF,
  parameter int FIFO_AW   = FIFO_AW_DEF,
  parameter int NBITS_CNT = NBITS_CNT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr_valid,
  input  logic [NBITS_D-1:0]   i_wr_data,
  output logic                 o_wr_ready,
  output logic                 o_tx_start,
  output logic [DBIT-1:0]      o_tx_data,
  input  logic                 i_tx_done,
  output logic                 o_busy,
  output logic [FIFO_AW:0]     o_fifo_count,
  output logic [NBITS_CNT-1:0] o_words_sent
);

  tx_state_e          state;
  logic [DBIT-1:0]    word_hi_r;
  logic [NBITS_D-1:0] fifo_dout;
  logic [FIFO_AW:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;

  assign push         = i_wr_valid && !fifo_full;
  assign pop          = (state == IDLE) && !fifo_empty;
  assign o_wr_ready   = !fifo_full;
  assign o_fifo_count = fifo_count;

  word_fifo #(
    .NBITS_D (NBITS_D),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (i_wr_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The low byte goes straight to o_tx_data at the pop edge, so only the
  // high byte needs holding until the first byte's done arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      word_hi_r    <= '0;
      o_tx_start   <= 1'b0;
      o_tx_data    <= '0;
      o_busy       <= 1'b0;
      o_words_sent <= '0;
    end else begin
      o_tx_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pop) begin
            word_hi_r  <= fifo_dout[NBITS_D-1:DBIT];
            o_tx_data  <= fifo_dout[DBIT-1:0];
            o_tx_start <= 1'b1;
            o_busy     <= 1'b1;
            state      <= SEND_LO;
          end
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (i_tx_done) begin
            o_tx_data  <= word_hi_r;
            o_tx_start <= 1'b1;
            state      <= SEND_HI;
          end
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (i_tx_done) begin
            o_words_sent <= o_words_sent + 1'b1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
